// File: rtl/xeng_vacc_sp.sv
// xeng_vacc_sp: double-buffered vector accumulator behind the single-pol X-engine.
// Sums acc_len windows into one bank, then streams that bank out while the other fills.

module xeng_vacc_sp #(
    parameter int IN_COMP_WIDTH  = 18,
    parameter int OUT_COMP_WIDTH = 32,
    parameter int VEC_LEN        = 2112,
    parameter int ADDR_BITS      = 12,
    parameter int MCNT_WIDTH     = 48,
    parameter int ACC_LEN_WIDTH  = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        sync_in,
    input  logic [2*IN_COMP_WIDTH-1:0]  din,
    input  logic                        din_vld,
    input  logic                        window_vld,
    input  logic [MCNT_WIDTH-1:0]       mcnt,
    input  logic [ACC_LEN_WIDTH-1:0]    acc_len,
    output logic [2*OUT_COMP_WIDTH-1:0] dout,
    output logic [ADDR_BITS-1:0]        dout_addr,
    output logic                        dout_vld,
    input  logic                        dout_rdy,
    output logic                        dout_sof,
    output logic [MCNT_WIDTH-1:0]       dout_mcnt,
    output logic [ACC_LEN_WIDTH-1:0]    dout_nwin_bad,
    output logic                        overflow,
    output logic                        sync_err,
    input  logic                        clr_err
);

    localparam int IW = IN_COMP_WIDTH;
    localparam int OW = OUT_COMP_WIDTH;
    localparam int DW = 2 * OW;
    localparam int AW = ADDR_BITS;
    localparam int LW = ACC_LEN_WIDTH;
    localparam int MW = MCNT_WIDTH;
    localparam logic [AW-1:0] LAST_ADDR = AW'(VEC_LEN - 1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_e;

    function automatic logic [OW-1:0] sat_add(input logic [OW-1:0] a,
                                              input logic [IW-1:0] b);
        logic [OW:0] s;
        s = {a[OW-1], a} + {{(OW+1-IW){b[IW-1]}}, b};
        if (s[OW] != s[OW-1])
            sat_add = s[OW] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
        else
            sat_add = s[OW-1:0];
    endfunction

    logic [AW-1:0]      wa_q, wa_d;
    logic [LW-1:0]      win_q, win_d, alen_q, alen_d, nbad_q, nbad_d;
    logic               win_ok_q, win_ok_d, bank_q, bank_d;
    logic [MW-1:0]      imcnt_q, imcnt_d, omcnt_q, omcnt_d;
    logic [LW-1:0]      onbad_q, onbad_d;
    logic               sync_err_q, sync_err_d, overflow_q, overflow_d;
    logic               s1_vld_q, s1_vld_d, s1_bank_q, s1_bank_d, s1_first_q, s1_first_d;
    logic [AW-1:0]      s1_addr_q, s1_addr_d, s2_addr_q, s2_addr_d;
    logic [2*IW-1:0]    s1_din_q, s1_din_d, s2_din_q, s2_din_d;
    logic               s2_vld_q, s2_vld_d, s2_bank_q, s2_bank_d, s2_first_q, s2_first_d;
    state_e             state_q, state_d;
    logic [AW-1:0]      ra_q, ra_d, iaddr_q, iaddr_d;
    logic               inflight_q, inflight_d, wp_q, wp_d, rp_q, rp_d;
    logic [1:0]         cnt_q, cnt_d;
    logic [AW+DW-1:0]   ent_q [2];
    logic [AW+DW-1:0]   ent_d [2];

    logic [AW-1:0]      cur_addr;
    logic [LW-1:0]      cur_win, cur_alen, alen_eff;
    logic               word0, win0, cur_ok, restart, done, swap;
    logic               pop, issue;
    logic [2:0]         occ;
    logic [DW-1:0]      old, wdata, rmw_rdata, ro_rdata;
    logic [AW+DW-1:0]   head;
    logic [DW-1:0]      mem [2**(AW+1)];

    always_comb begin
        wa_d       = wa_q;
        win_d      = win_q;
        alen_d     = alen_q;
        nbad_d     = nbad_q;
        win_ok_d   = win_ok_q;
        bank_d     = bank_q;
        imcnt_d    = imcnt_q;
        omcnt_d    = omcnt_q;
        onbad_d    = onbad_q;
        sync_err_d = sync_err_q & ~clr_err;
        overflow_d = overflow_q & ~clr_err;
        done       = 1'b0;
        swap       = 1'b0;
        restart    = din_vld && sync_in && (wa_q != '0);
        cur_addr   = sync_in ? '0 : wa_q;
        cur_win    = restart ? '0 : win_q;
        word0      = (cur_addr == '0);
        win0       = (cur_win == '0);
        alen_eff   = (acc_len == '0) ? LW'(1) : acc_len;
        cur_alen   = (word0 && win0) ? alen_eff : alen_q;
        cur_ok     = word0 ? window_vld : win_ok_q;
        if (din_vld) begin
            if (restart)
                sync_err_d = 1'b1;
            if (word0) begin
                win_ok_d = window_vld;
                if (win0) begin
                    alen_d  = alen_eff;
                    imcnt_d = mcnt;
                    nbad_d  = LW'(!window_vld);
                end else if (!window_vld) begin
                    nbad_d = nbad_q + LW'(1);
                end
            end
            if (cur_addr == LAST_ADDR) begin
                wa_d = '0;
                if (cur_win == cur_alen - LW'(1)) begin
                    win_d = '0;
                    done  = 1'b1;
                end else begin
                    win_d = cur_win + LW'(1);
                end
            end else begin
                wa_d  = cur_addr + AW'(1);
                win_d = cur_win;
            end
        end
        // A busy readout keeps the bank; the next integration overwrites it.
        if (done) begin
            if (state_q == IDLE) begin
                swap    = 1'b1;
                bank_d  = ~bank_q;
                omcnt_d = imcnt_q;
                onbad_d = nbad_q;
            end else begin
                overflow_d = 1'b1;
            end
        end
    end

    always_comb begin
        s1_vld_d   = din_vld;
        s1_addr_d  = cur_addr;
        s1_bank_d  = bank_q;
        s1_first_d = win0;
        s1_din_d   = cur_ok ? din : '0;
        s2_vld_d   = s1_vld_q;
        s2_addr_d  = s1_addr_q;
        s2_bank_d  = s1_bank_q;
        s2_first_d = s1_first_q;
        s2_din_d   = s1_din_q;
        old        = s2_first_q ? '0 : rmw_rdata;
        wdata      = {sat_add(old[DW-1:OW], s2_din_q[2*IW-1:IW]),
                      sat_add(old[OW-1:0], s2_din_q[IW-1:0])};
    end

    always_ff @(posedge clk) begin
        if (s2_vld_q)
            mem[{s2_bank_q, s2_addr_q}] <= wdata;
        rmw_rdata <= mem[{s1_bank_q, s1_addr_q}];
        if (issue)
            ro_rdata <= mem[{~bank_q, ra_q}];
    end

    // Issue only when the skid buffer can take every read already in flight.
    always_comb begin
        head       = ent_q[rp_q];
        pop        = (cnt_q != 2'd0) && dout_rdy;
        occ        = 3'(cnt_q) + 3'(inflight_q) - 3'(pop);
        issue      = (state_q == READ) && (occ <= 3'd1);
        state_d    = state_q;
        ra_d       = ra_q;
        inflight_d = issue;
        iaddr_d    = issue ? ra_q : iaddr_q;
        ent_d      = ent_q;
        if (inflight_q)
            ent_d[wp_q] = {iaddr_q, ro_rdata};
        wp_d  = wp_q ^ inflight_q;
        rp_d  = rp_q ^ pop;
        cnt_d = cnt_q + 2'(inflight_q) - 2'(pop);
        unique case (state_q)
            IDLE: begin
                if (swap) begin
                    state_d = READ;
                    ra_d    = '0;
                end
            end
            READ: begin
                if (issue) begin
                    ra_d = ra_q + AW'(1);
                    if (ra_q == LAST_ADDR)
                        state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && head[AW+DW-1:DW] == LAST_ADDR)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wa_q       <= '0;
            win_q      <= '0;
            alen_q     <= '0;
            nbad_q     <= '0;
            win_ok_q   <= 1'b0;
            bank_q     <= 1'b0;
            imcnt_q    <= '0;
            omcnt_q    <= '0;
            onbad_q    <= '0;
            sync_err_q <= 1'b0;
            overflow_q <= 1'b0;
            s1_vld_q   <= 1'b0;
            s1_addr_q  <= '0;
            s1_bank_q  <= 1'b0;
            s1_first_q <= 1'b0;
            s1_din_q   <= '0;
            s2_vld_q   <= 1'b0;
            s2_addr_q  <= '0;
            s2_bank_q  <= 1'b0;
            s2_first_q <= 1'b0;
            s2_din_q   <= '0;
            state_q    <= IDLE;
            ra_q       <= '0;
            iaddr_q    <= '0;
            inflight_q <= 1'b0;
            wp_q       <= 1'b0;
            rp_q       <= 1'b0;
            cnt_q      <= 2'd0;
            ent_q      <= '{default: '0};
        end else begin
            wa_q       <= wa_d;
            win_q      <= win_d;
            alen_q     <= alen_d;
            nbad_q     <= nbad_d;
            win_ok_q   <= win_ok_d;
            bank_q     <= bank_d;
            imcnt_q    <= imcnt_d;
            omcnt_q    <= omcnt_d;
            onbad_q    <= onbad_d;
            sync_err_q <= sync_err_d;
            overflow_q <= overflow_d;
            s1_vld_q   <= s1_vld_d;
            s1_addr_q  <= s1_addr_d;
            s1_bank_q  <= s1_bank_d;
            s1_first_q <= s1_first_d;
            s1_din_q   <= s1_din_d;
            s2_vld_q   <= s2_vld_d;
            s2_addr_q  <= s2_addr_d;
            s2_bank_q  <= s2_bank_d;
            s2_first_q <= s2_first_d;
            s2_din_q   <= s2_din_d;
            state_q    <= state_d;
            ra_q       <= ra_d;
            iaddr_q    <= iaddr_d;
            inflight_q <= inflight_d;
            wp_q       <= wp_d;
            rp_q       <= rp_d;
            cnt_q      <= cnt_d;
            ent_q      <= ent_d;
        end
    end

    assign dout          = head[DW-1:0];
    assign dout_addr     = head[AW+DW-1:DW];
    assign dout_vld      = (cnt_q != 2'd0);
    assign dout_sof      = dout_vld && (dout_addr == '0);
    assign dout_mcnt     = omcnt_q;
    assign dout_nwin_bad = onbad_q;
    assign overflow      = overflow_q;
    assign sync_err      = sync_err_q;

endmodule

// File: tb/tb_xeng_vacc_sp.sv
// tb_xeng_vacc_sp: random and directed stimulus for xeng_vacc_sp,
// checked against an array-based accumulation model.

module tb_xeng_vacc_sp;

    localparam int IW = 18;
    localparam int OW = 20;
    localparam int VL = 16;
    localparam int AW = 4;
    localparam int MW = 48;
    localparam int LW = 16;
    localparam int SMAX = (1 << (OW - 1)) - 1;
    localparam int SMIN = -(1 << (OW - 1));

    typedef struct packed {
        logic [MW-1:0]             mc;
        logic [LW-1:0]             nbad;
        logic [VL-1:0][2*OW-1:0]   data;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            sync_in = 1'b0;
    logic [2*IW-1:0] din = '0;
    logic            din_vld = 1'b0;
    logic            window_vld = 1'b0;
    logic [MW-1:0]   mcnt = '0;
    logic [LW-1:0]   acc_len = '0;
    logic            dout_rdy = 1'b0;
    logic            clr_err = 1'b0;
    logic [2*OW-1:0] dout;
    logic [AW-1:0]   dout_addr;
    logic            dout_vld;
    logic            dout_sof;
    logic [MW-1:0]   dout_mcnt;
    logic [LW-1:0]   dout_nwin_bad;
    logic            overflow;
    logic            sync_err;

    vec_t            exp_q[$];
    int              n_chk = 0;
    int              n_fail = 0;
    int              rdy_mode = 0;
    logic [MW-1:0]   mcnt_base = 48'h0000_1234_0000;
    logic [2*OW-1:0] got_v [VL];
    int              mon_idx = 0;
    logic            stall_hold = 1'b0;
    logic [63:0]     held = '0;

    xeng_vacc_sp #(
        .IN_COMP_WIDTH (IW),
        .OUT_COMP_WIDTH(OW),
        .VEC_LEN       (VL),
        .ADDR_BITS     (AW),
        .MCNT_WIDTH    (MW),
        .ACC_LEN_WIDTH (LW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sync_in      (sync_in),
        .din          (din),
        .din_vld      (din_vld),
        .window_vld   (window_vld),
        .mcnt         (mcnt),
        .acc_len      (acc_len),
        .dout         (dout),
        .dout_addr    (dout_addr),
        .dout_vld     (dout_vld),
        .dout_rdy     (dout_rdy),
        .dout_sof     (dout_sof),
        .dout_mcnt    (dout_mcnt),
        .dout_nwin_bad(dout_nwin_bad),
        .overflow     (overflow),
        .sync_err     (sync_err),
        .clr_err      (clr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int sat(input int v);
        if (v > SMAX) return SMAX;
        if (v < SMIN) return SMIN;
        return v;
    endfunction

    function automatic int rnd_in();
        return int'($urandom_range(0, (1 << IW) - 1)) - (1 << (IW - 1));
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       dout_rdy = 1'b1;
                1:       dout_rdy = ($urandom_range(0, 9) < 3);
                default: dout_rdy = 1'b0;
            endcase
        end
    end

    // Output monitor: handshakes are sampled mid-cycle, ahead of the accepting edge.
    always @(negedge clk) begin
        vec_t e;
        if (!rst_n) begin
            mon_idx    = 0;
            stall_hold = 1'b0;
        end else begin
            if (stall_hold) begin
                chk("stall_vld", 64'(dout_vld), 64'd1);
                chk("stall_hold", 64'({dout_sof, dout_addr, dout}), held);
            end
            if (dout_vld && dout_rdy) begin
                stall_hold = 1'b0;
                chk("addr", 64'(dout_addr), 64'(mon_idx));
                chk("sof", 64'(dout_sof), 64'(mon_idx == 0));
                got_v[mon_idx] = dout;
                if (mon_idx == VL - 1) begin
                    mon_idx = 0;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_vec", 64'd1, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        for (int i = 0; i < VL; i++)
                            chk("word", 64'(got_v[i]), 64'(e.data[i]));
                        chk("mcnt", 64'(dout_mcnt), 64'(e.mc));
                        chk("nwin_bad", 64'(dout_nwin_bad), 64'(e.nbad));
                    end
                end else begin
                    mon_idx++;
                end
            end else if (dout_vld) begin
                stall_hold = 1'b1;
                held = 64'({dout_sof, dout_addr, dout});
            end else begin
                stall_hold = 1'b0;
            end
        end
    end

    task automatic feed(input logic s, input logic ok, input int re,
                        input int im, input logic [MW-1:0] mc);
        @(posedge clk);
        #1;
        sync_in    = s;
        din_vld    = 1'b1;
        window_vld = ok;
        din        = {re[IW-1:0], im[IW-1:0]};
        mcnt       = mc;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        din_vld = 1'b0;
        sync_in = 1'b0;
    endtask

    task automatic run_integ(input int alen, input bit fix, input int fre,
                             input int fim, input logic [31:0] bad,
                             input bit gaps, input bit push);
        int   mre [VL];
        int   mim [VL];
        int   eff, re, im, nb;
        logic ok;
        vec_t e;
        eff     = (alen == 0) ? 1 : alen;
        nb      = 0;
        acc_len = LW'(alen);
        for (int w = 0; w < eff; w++) begin
            ok = !bad[w];
            if (!ok) nb++;
            for (int a = 0; a < VL; a++) begin
                if (gaps && $urandom_range(0, 3) == 0) idle();
                re = fix ? fre : rnd_in();
                im = fix ? fim : rnd_in();
                feed(a == 0, ok, re, im, mcnt_base + MW'(w));
                if (w == 0) begin
                    mre[a] = ok ? re : 0;
                    mim[a] = ok ? im : 0;
                end else begin
                    mre[a] = sat(mre[a] + (ok ? re : 0));
                    mim[a] = sat(mim[a] + (ok ? im : 0));
                end
            end
        end
        idle();
        e.mc   = mcnt_base;
        e.nbad = LW'(nb);
        for (int a = 0; a < VL; a++)
            e.data[a] = {mre[a][OW-1:0], mim[a][OW-1:0]};
        mcnt_base = mcnt_base + 48'd100;
        if (push) exp_q.push_back(e);
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 3000 && exp_q.size() != 0; i++)
            @(posedge clk);
        chk(tag, 64'(exp_q.size()), 64'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic pulse_clr();
        @(posedge clk);
        #1;
        clr_err = 1'b1;
        @(posedge clk);
        #1;
        clr_err = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_vld"}, 64'(dout_vld), 64'd0);
        chk({tag, "_dout"}, 64'(dout), 64'd0);
        chk({tag, "_addr"}, 64'(dout_addr), 64'd0);
        chk({tag, "_sof"}, 64'(dout_sof), 64'd0);
        chk({tag, "_mcnt"}, 64'(dout_mcnt), 64'd0);
        chk({tag, "_nbad"}, 64'(dout_nwin_bad), 64'd0);
        chk({tag, "_ovf"}, 64'(overflow), 64'd0);
        chk({tag, "_serr"}, 64'(sync_err), 64'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst_n = 1'b1;

        rdy_mode = 0;
        run_integ(3, 1'b1, 1, -2, 32'h0, 1'b0, 1'b1);
        wait_drain("basic_drain");

        run_integ(2, 1'b1, 5, -7, 32'h2, 1'b0, 1'b1);
        wait_drain("badwin_drain");

        run_integ(16, 1'b1, (1 << 17) - 1, -(1 << 17), 32'h0, 1'b0, 1'b1);
        wait_drain("sat_a_drain");
        run_integ(16, 1'b1, -(1 << 17), (1 << 17) - 1, 32'h0, 1'b0, 1'b1);
        wait_drain("sat_b_drain");

        rdy_mode = 1;
        run_integ(0, 1'b0, 0, 0, $urandom, 1'b1, 1'b1);
        wait_drain("alen0_drain");
        for (int k = 0; k < 4; k++) begin
            run_integ(int'($urandom_range(1, 4)), 1'b0, 0, 0, $urandom,
                      1'b1, 1'b1);
            wait_drain("rand_drain");
        end

        rdy_mode = 2;
        run_integ(2, 1'b0, 0, 0, 32'h0, 1'b0, 1'b1);
        run_integ(1, 1'b0, 0, 0, 32'h0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("overflow_set", 64'(overflow), 64'd1);
        chk("stalled_vld", 64'(dout_vld), 64'd1);
        rdy_mode = 0;
        wait_drain("overflow_drain");
        pulse_clr();
        chk("overflow_clr", 64'(overflow), 64'd0);
        chk("sync_err_clean", 64'(sync_err), 64'd0);

        acc_len = LW'(2);
        for (int a = 0; a < 7; a++)
            feed(a == 0, 1'b1, rnd_in(), rnd_in(), mcnt_base);
        mcnt_base = mcnt_base + 48'd7;
        run_integ(2, 1'b0, 0, 0, 32'h0, 1'b1, 1'b1);
        chk("sync_err_set", 64'(sync_err), 64'd1);
        wait_drain("sync_drain");
        chk("sync_no_ovf", 64'(overflow), 64'd0);
        pulse_clr();
        chk("sync_err_clr", 64'(sync_err), 64'd0);

        rdy_mode = 1;
        run_integ(1, 1'b0, 0, 0, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 50 && !dout_vld; i++)
            @(negedge clk);
        chk("rst_vld_seen", 64'(dout_vld), 64'd1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        rdy_mode = 0;
        run_integ(2, 1'b0, 0, 0, 32'h1, 1'b0, 1'b1);
        wait_drain("recover_drain");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/xeng_vacc_sp.md
Name: xeng_vacc_sp

Overview:
- Receiver for the single-pol X-engine output stream.
- Accumulates successive X-engine output vectors (one per window, VEC_LEN words) into a double-buffered on-chip accumulator for a runtime-programmable number of windows.
- On completion of an integration, swaps banks and streams the finished vector out on a valid/ready interface, with the mcnt of the integration's first window.
- Sits directly after the X-engine top, ahead of the packetizer.

Parameters:
IN_COMP_WIDTH, 18, signed width of each re/im component of din
OUT_COMP_WIDTH, 32, signed width of each re/im accumulator component
VEC_LEN, 2112, words per X-engine window (N_ANTS*N_TAPS); must be > 8
ADDR_BITS, 12, address width, 2^ADDR_BITS >= VEC_LEN
MCNT_WIDTH, 48, mcnt bus width
ACC_LEN_WIDTH, 16, width of acc_len

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
sync_in  in  1  X-engine sync_out; marks word 0 of a window
din  in  2*IN_COMP_WIDTH  {re, im} signed, from X-engine dout
din_vld  in  1  X-engine vld_out; qualifies din
window_vld  in  1  X-engine window_vld_out; low = window data invalid
mcnt  in  MCNT_WIDTH  X-engine mcnt_out
acc_len  in  ACC_LEN_WIDTH  windows per integration; 0 treated as 1
dout  out  2*OUT_COMP_WIDTH  {re, im} accumulated result
dout_addr  out  ADDR_BITS  word index of dout
dout_vld  out  1  output valid
dout_rdy  in  1  downstream ready
dout_sof  out  1  high with dout_addr==0 word
dout_mcnt  out  MCNT_WIDTH  mcnt of first window in integration; stable for whole readout
dout_nwin_bad  out  ACC_LEN_WIDTH  windows in integration with window_vld low
overflow  out  1  sticky: integration dropped because readout was busy
sync_err  out  1  sticky: sync_in arrived mid-window
clr_err  in  1  synchronous clear of overflow and sync_err

Behaviour:
- Reset: all outputs 0. Write address, window count and bank select are 0. Readout FSM is IDLE. Memory contents are don't-care.
- Write address wa advances by 1 on each din_vld. sync_in forces the word arriving with it to wa=0.
  - sync_in with wa!=0 is a mid-window sync: set sync_err, discard the current integration, restart at window 0 in the same bank.
  - sync_in and din_vld in the same cycle: din is word 0.
- Window start (word 0): sample window_vld into win_ok for the whole window.
- Integration start (window 0): sample acc_len (0 -> 1) and mcnt.
- Per word, read-modify-write the active bank at wa:
  - window 0: store sext(din) if win_ok, else 0.
  - later windows: store mem + (win_ok ? sext(din) : 0).
  - re and im add independently, each saturating to signed OUT_COMP_WIDTH min/max.
- RMW pipeline depth is at most 4 cycles. No same-address hazard exists because VEC_LEN > 8.
- Count windows with win_ok low. The count latches into dout_nwin_bad at swap.
- Integration completes when word VEC_LEN-1 of window acc_len-1 is written:
  - readout FSM IDLE: flip bank, latch dout_mcnt and dout_nwin_bad, FSM -> READ.
  - readout FSM busy: set overflow, do not flip; the next integration overwrites the same bank.
- Readout FSM, IDLE -> READ -> DRAIN -> IDLE:
  - READ issues reads of 0..VEC_LEN-1 from the inactive bank.
  - A 2-entry skid buffer absorbs the RAM read latency, so no word is lost under backpressure.
  - dout, dout_addr and dout_sof hold while dout_vld && !dout_rdy.
  - First dout_vld occurs within 4 cycles of the swap.
  - With dout_rdy held high, one word is output per cycle.
  - DRAIN waits until the last word is accepted, then returns to IDLE.
- clr_err clears the sticky flags. A set event in the same cycle wins.
- rst_n mid-operation aborts the integration and readout immediately. dout_vld drops asynchronously.

Test Plan:
- VEC_LEN=16, acc_len=3, din re=1 im=-2 every word, window_vld=1, dout_rdy=1 -> 16 words re=3 im=-6, addresses 0..15, dout_sof on addr 0, dout_mcnt = mcnt of first window, dout_nwin_bad=0.
- acc_len=2, second window window_vld=0, din re=5 -> re=5 for all words, dout_nwin_bad=1.
- OUT_COMP_WIDTH=20, din re=2^17-1, acc_len=16 -> re=2^19-1 (saturated); din re=-2^17 -> re=-2^19.
- dout_rdy toggled by a random 30% duty pattern during readout -> all 16 words delivered in order, no duplicates or gaps, dout stable while stalled.
- dout_rdy=0 held through the next integration completion -> overflow=1, first vector still read intact once dout_rdy=1; clr_err -> overflow=0.
- sync_in at wa=7 -> sync_err=1, next integration restarts at window 0 and yields correct sums. rst_n pulsed mid-readout -> dout_vld=0 immediately, all outputs 0.
